// File: rtl/ntt_pkg.sv
// Shared NTT definitions: transform size, twiddle address width and the
// scheduler state enumeration.
package ntt_pkg;

  localparam int NTT_N    = 32;
  localparam int NTT_LOGN = 5;
  localparam int PSI_W    = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational Cooley-Tukey address mapping: (stage, butterfly, direction)
// -> operand addresses and twiddle address. Outputs are forced to zero when
// not enabled so the scheduler presents quiet addresses outside ISSUE.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int N    = NTT_N,
  parameter int LOGN = NTT_LOGN
) (
  input  logic                     en,
  input  logic [$clog2(LOGN)-1:0]  s,
  input  logic [LOGN-2:0]          b,
  input  logic                     inverse,
  output logic [LOGN-1:0]          addr_a,
  output logic [LOGN-1:0]          addr_b,
  output logic [PSI_W-1:0]         psi_addr
);

  localparam int TW = PSI_W - 2;

  logic [LOGN-1:0] t;
  logic [LOGN-1:0] g;
  logic [LOGN-1:0] j;
  logic [LOGN-1:0] a;
  logic [TW-1:0]   psum;

  // Butterfly span t, group index g, offset j within the group; a = 2*t*g + j
  always_comb begin
    t        = LOGN'(N / 2) >> s;
    g        = LOGN'(b) >> (LOGN - 1 - int'(s));
    j        = LOGN'(b) & (t - LOGN'(1));
    a        = (g << (LOGN - int'(s))) | j;
    psum     = TW'(g) + (TW'(1) << s);
    addr_a   = '0;
    addr_b   = '0;
    psi_addr = '0;
    if (en) begin
      addr_a   = a;
      addr_b   = a + t;
      psi_addr = {inverse, 1'b0, psum};
    end
  end

endmodule

// File: rtl/ntt_scheduler.sv
// NTT butterfly scheduler: walks LOGN stages of N/2 butterflies, issues one
// command per handshake, tracks outstanding write-backs and holds a stage
// barrier until every result of the current stage has retired.
module ntt_scheduler
  import ntt_pkg::*;
#(
  parameter int N    = NTT_N,
  parameter int LOGN = NTT_LOGN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inverse,
  output logic              busy,
  output logic              done,
  output logic              bf_valid,
  input  logic              bf_ready,
  output logic [LOGN-1:0]   addr_a,
  output logic [LOGN-1:0]   addr_b,
  output logic [PSI_W-1:0]  psi_addr,
  input  logic              bf_retire,
  output logic              err
);

  localparam int SW = $clog2(LOGN);
  localparam int BW = LOGN - 1;
  localparam logic [SW-1:0]   S_LAST  = SW'(LOGN - 1);
  localparam logic [BW-1:0]   B_LAST  = BW'(N / 2 - 1);
  localparam logic [LOGN-1:0] OUT_MAX = LOGN'(N / 2);

  state_t          state;
  state_t          state_nxt;
  logic [SW-1:0]   s;
  logic [BW-1:0]   b;
  logic            inv_q;
  logic [LOGN-1:0] outst;
  logic [LOGN-1:0] outst_nxt;
  logic            err_q;
  logic            hs;
  logic            drained;
  logic            last_cmd;

  assign hs       = bf_valid & bf_ready;
  assign last_cmd = (b == B_LAST);
  assign drained  = (outst_nxt == '0);
  assign err      = err_q;

  // Outstanding count after this cycle: issue and retire cancel, saturate at N/2, floor at 0
  always_comb begin
    outst_nxt = outst;
    if (hs && !bf_retire) begin
      if (outst != OUT_MAX) outst_nxt = outst + LOGN'(1);
    end else if (!hs && bf_retire) begin
      if (outst != '0) outst_nxt = outst - LOGN'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DRAIN is the stage barrier
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (hs && last_cmd) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = (s != S_LAST) ? ISSUE : FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    bf_valid = 1'b0;
    case (state)
      ISSUE:   begin busy = 1'b1; bf_valid = 1'b1; end
      DRAIN:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // Stage/butterfly counters, direction latch, outstanding counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      b     <= '0;
      inv_q <= 1'b0;
      outst <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        s     <= '0;
        b     <= '0;
        inv_q <= inverse;
      end
      if (hs) b <= b + BW'(1);
      if (state == DRAIN && drained && s != S_LAST) begin
        s <= s + SW'(1);
        b <= '0;
      end
      outst <= outst_nxt;
      if (bf_retire && !hs && outst == '0) err_q <= 1'b1;
    end
  end

  ntt_addr_gen #(
    .N    (N),
    .LOGN (LOGN)
  ) u_addr_gen (
    .en       (state == ISSUE),
    .s        (s),
    .b        (b),
    .inverse  (inv_q),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .psi_addr (psi_addr)
  );

endmodule

// File: tb/tb_ntt_scheduler.sv
// Self-checking bench for ntt_scheduler: randomized ready stalls and retire
// latencies checked every cycle against a Cooley-Tukey loop model.
module tb_ntt_scheduler;

  localparam int N     = 32;
  localparam int LOGN  = 5;
  localparam int HALF  = N / 2;
  localparam int TOTAL = LOGN * HALF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            inverse = 1'b0;
  logic            busy;
  logic            done;
  logic            bf_valid;
  logic            bf_ready = 1'b0;
  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] addr_b;
  logic [6:0]      psi_addr;
  logic            bf_retire = 1'b0;
  logic            err;

  always #5 clk = ~clk;

  ntt_scheduler #(.N(N), .LOGN(LOGN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inverse   (inverse),
    .busy      (busy),
    .done      (done),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .psi_addr  (psi_addr),
    .bf_retire (bf_retire),
    .err       (err)
  );

  int exp_a [2][TOTAL];
  int exp_b [2][TOTAL];
  int exp_p [2][TOTAL];
  int obs_a [TOTAL];
  int obs_b [TOTAL];
  int obs_p [TOTAL];
  int ref_a [TOTAL];
  int ref_b [TOTAL];
  int ref_p [TOTAL];
  bit due [64];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;
  bit stall_mode = 0;

  bit busy_m = 0, done_pend = 0, err_m = 0, rst_prev = 0, stall_prev = 0, armed = 0;
  int out_m = 0, idx = 0, retired = 0, inv_m = 0, done_cnt = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference command order: textbook Cooley-Tukey triple loop
  task automatic build_model();
    for (int inv = 0; inv < 2; inv++) begin
      int k = 0;
      int t = N / 2;
      for (int st = 0; st < LOGN; st++) begin
        int m = 1 << st;
        for (int i = 0; i < m; i++) begin
          for (int jj = 2 * i * t; jj < 2 * i * t + t; jj++) begin
            exp_a[inv][k] = jj;
            exp_b[inv][k] = jj + t;
            exp_p[inv][k] = inv * 64 + m + i;
            k++;
          end
        end
        t = t / 2;
      end
    end
  endtask

  // One clock cycle: drive after the rising edge, check and update the model on the falling edge
  task automatic step(input logic rst_i, input logic start_i, input logic inv_i, input logic extra_ret);
    bit hs;
    @(posedge clk);
    cyc++;
    #1;
    rst       = rst_i;
    start     = start_i;
    inverse   = inv_i;
    bf_ready  = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    bf_retire = due[cyc % 64] | extra_ret;
    due[cyc % 64] = 0;
    @(negedge clk);
    hs = bf_valid && bf_ready;
    if (rst_prev) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", bf_valid, 0);
      chk("rst_addr_a", addr_a, 0);
      chk("rst_addr_b", addr_b, 0);
      chk("rst_psi", psi_addr, 0);
      chk("rst_err", err, 0);
      armed = 1;
    end else if (armed) begin
      chk("done", done, done_pend);
      chk("busy", busy, busy_m);
      chk("err", err, err_m);
      if (done) done_cnt++;
      if (stall_prev) chk("stall_valid_held", bf_valid, 1);
      if (!busy_m || idx >= TOTAL) begin
        chk("valid_outside_issue", bf_valid, 0);
      end else if (bf_valid) begin
        int req = HALF * (idx / HALF);
        chk("cmd_addr_a", addr_a, exp_a[inv_m][idx]);
        chk("cmd_addr_b", addr_b, exp_b[inv_m][idx]);
        chk("cmd_psi", psi_addr, exp_p[inv_m][idx]);
        chk("stage_barrier_retires", (retired >= req) ? req : retired, req);
      end
    end
    if (rst) begin
      busy_m = 0; done_pend = 0; out_m = 0; err_m = 0; idx = 0; retired = 0;
    end else begin
      if (done_pend) done_pend = 0;
      else if (start && !busy_m) begin
        busy_m = 1; idx = 0; retired = 0; inv_m = int'(inverse);
      end
      if (hs && busy_m && idx < TOTAL) begin
        obs_a[idx] = int'(addr_a);
        obs_b[idx] = int'(addr_b);
        obs_p[idx] = int'(psi_addr);
        idx++;
        due[(cyc + lat) % 64] = 1;
      end
      if (hs && bf_retire) retired++;
      else if (hs) out_m = (out_m < HALF) ? out_m + 1 : out_m;
      else if (bf_retire) begin
        if (out_m == 0) err_m = 1;
        else begin out_m--; retired++; end
      end
      if (busy_m && idx == TOTAL && out_m == 0 && !hs) begin
        busy_m = 0; done_pend = 1;
      end
    end
    stall_prev = !rst && bf_valid && !bf_ready;
    rst_prev = rst;
  endtask

  task automatic run_tf(input logic inv_i, input int lat_i, input bit stall_i, input int abort_at);
    bit fin = 0;
    bit ab = 0;
    lat = lat_i;
    stall_mode = stall_i;
    done_cnt = 0;
    step(0, 1, inv_i, 0);
    for (int k = 0; k < 3000 && !fin && !ab; k++) begin
      step(0, 0, inv_i, 0);
      if (done_cnt > 0) fin = 1;
      else if (abort_at > 0 && idx == abort_at) ab = 1;
    end
    if (!fin && !ab) chk("run_timeout_done_count", done_cnt, 1);
    if (fin) begin
      step(0, 0, inv_i, 0);
      step(0, 0, inv_i, 0);
      chk("handshakes_per_run", idx, TOTAL);
      chk("done_pulses_per_run", done_cnt, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got 1, expected 0");
    $fatal(1, "time limit");
  end

  initial begin
    int diffs;
    int cnt;
    for (int k = 0; k < 64; k++) due[k] = 0;
    build_model();
    // Pin the model with hand-derived values
    chk("model_first_a", exp_a[0][0], 0);
    chk("model_first_b", exp_b[0][0], 16);
    chk("model_stage1_b", exp_b[0][16], 8);
    chk("model_last_a", exp_a[0][TOTAL-1], 30);
    chk("model_last_psi", exp_p[0][TOTAL-1], 31);
    chk("model_inv_psi", exp_p[1][0], 65);

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Forward, full ready, retire one cycle after each handshake
    run_tf(0, 1, 0, 0);
    chk("first_cmd_a", obs_a[0], 0);
    chk("first_cmd_b", obs_b[0], 16);
    chk("first_cmd_psi", obs_p[0], 1);
    chk("cmd16_a", obs_a[15], 15);
    chk("cmd16_b", obs_b[15], 31);
    chk("cmd16_psi", obs_p[15], 1);
    chk("stage1_first_a", obs_a[16], 0);
    chk("stage1_first_b", obs_b[16], 8);
    chk("stage1_first_psi", obs_p[16], 2);
    chk("last_cmd_a", obs_a[TOTAL-1], 30);
    chk("last_cmd_b", obs_b[TOTAL-1], 31);
    chk("last_cmd_psi", obs_p[TOTAL-1], 31);
    for (int k = 0; k < TOTAL; k++) begin
      ref_a[k] = obs_a[k]; ref_b[k] = obs_b[k]; ref_p[k] = obs_p[k];
    end

    // Inverse direction
    run_tf(1, 1, 0, 0);
    cnt = 0;
    for (int k = 0; k < TOTAL; k++) cnt += (obs_p[k] >> 6) & 1;
    chk("inverse_bit6_count", cnt, TOTAL);
    chk("inverse_first_psi", obs_p[0], 65);

    // Random ready stalls
    run_tf(0, 2, 1, 0);
    diffs = 0;
    for (int k = 0; k < TOTAL; k++)
      if (obs_a[k] != ref_a[k] || obs_b[k] != ref_b[k] || obs_p[k] != ref_p[k]) diffs++;
    chk("stall_sequence_diffs", diffs, 0);

    // Long retire latency exercises the stage barrier
    run_tf(0, 6, 0, 0);
    run_tf(1, 6, 1, 0);

    // Spurious retire while idle sets the sticky error
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("err_after_spurious", err, 1);
    run_tf(0, 1, 0, 0);
    chk("err_sticky_after_run", err, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("err_cleared_by_rst", err, 0);

    // Reset in the middle of a transform with retires still in flight
    run_tf(0, 6, 0, 40);
    chk("abort_point_handshakes", idx, 40);
    step(1, 0, 0, 0);
    done_cnt = 0;
    for (int k = 0; k < 12; k++) step(0, 0, 0, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("err_from_stale_retires", err, 1);
    run_tf(0, 1, 0, 0);
    chk("restart_first_a", obs_a[0], 0);
    chk("restart_first_b", obs_b[0], 16);
    chk("restart_first_psi", obs_p[0], 1);

    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
